// File: rtl/bcd_7seg_scan_driver_if.sv
// Display-side bundle of the BCD scan driver: digit data and CD4511-style controls in,
// multiplexed segment bus, digit enables and scan tick out.
interface bcd_7seg_scan_driver_if #(
    parameter int N_DIGITS = 4
);
    logic [4*N_DIGITS-1:0] bcd_in;
    logic                  le;
    logic                  lt_n;
    logic                  bi_n;
    logic [6:0]            seg;
    logic [N_DIGITS-1:0]   dig_en;
    logic                  scan_tick;

    modport master (
        output bcd_in, le, lt_n, bi_n,
        input  seg, dig_en, scan_tick
    );

    modport slave (
        input  bcd_in, le, lt_n, bi_n,
        output seg, dig_en, scan_tick
    );
endinterface

// File: rtl/bcd_7seg_scan_driver.sv
// Multi-digit BCD to 7-segment scan driver with lamp test, blanking and latch enable.
// Optional leading-zero blanking is built when LZB_EN is defined.
module bcd_7seg_scan_driver #(
    parameter int N_DIGITS         = 4,
    parameter int CLK_DIV          = 1000,
    parameter int SEG_ACTIVE_LOW   = 0,
    parameter int DIGIT_ACTIVE_LOW = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    bcd_7seg_scan_driver_if.slave      bus
);
    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int PW = $clog2(CLK_DIV);
    localparam logic [6:0]          SEG_XOR = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [N_DIGITS-1:0] DIG_XOR = (DIGIT_ACTIVE_LOW != 0) ? {N_DIGITS{1'b1}} : '0;

    logic [4*N_DIGITS-1:0] latch;
    logic [PW-1:0]         presc;
    logic [IW-1:0]         idx;
    logic [3:0]            cur_digit;
    logic [N_DIGITS-1:0]   onehot;
    logic [6:0]            seg_logical;
`ifdef LZB_EN
    logic [N_DIGITS-1:0]   shown;
    logic                  nz_acc;
    logic                  cur_shown;
`endif

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'b1111110;
            4'd1:    decode = 7'b0110000;
            4'd2:    decode = 7'b1101101;
            4'd3:    decode = 7'b1111001;
            4'd4:    decode = 7'b0110011;
            4'd5:    decode = 7'b1011011;
            4'd6:    decode = 7'b0011111;
            4'd7:    decode = 7'b1110000;
            4'd8:    decode = 7'b1111111;
            4'd9:    decode = 7'b1110011;
            default: decode = 7'b0000000;
        endcase
    endfunction

    always_comb begin
        cur_digit = '0;
        onehot    = '0;
`ifdef LZB_EN
        // A digit is shown if it or any higher digit is nonzero; digit 0 always shows.
        shown     = '0;
        nz_acc    = 1'b0;
        cur_shown = 1'b1;
        for (int k = N_DIGITS - 1; k >= 0; k--) begin
            nz_acc   = nz_acc | (|latch[4*k +: 4]);
            shown[k] = nz_acc | (k == 0);
        end
`endif
        for (int k = 0; k < N_DIGITS; k++) begin
            if (idx == IW'(k)) begin
                cur_digit = latch[4*k +: 4];
                onehot[k] = 1'b1;
`ifdef LZB_EN
                cur_shown = shown[k];
`endif
            end
        end
        if (!bus.lt_n)
            seg_logical = 7'b1111111;
        else if (!bus.bi_n)
            seg_logical = 7'b0000000;
`ifdef LZB_EN
        else if (!cur_shown)
            seg_logical = 7'b0000000;
`endif
        else
            seg_logical = decode(cur_digit);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            latch         <= '0;
            presc         <= '0;
            idx           <= '0;
            bus.scan_tick <= 1'b0;
            bus.seg       <= SEG_XOR;
            bus.dig_en    <= DIG_XOR;
        end else begin
            if (!bus.le)
                latch <= bus.bcd_in;
            if (presc == PW'(CLK_DIV - 1)) begin
                presc         <= '0;
                bus.scan_tick <= 1'b1;
                idx           <= (idx == IW'(N_DIGITS - 1)) ? '0 : idx + 1'b1;
            end else begin
                presc         <= presc + 1'b1;
                bus.scan_tick <= 1'b0;
            end
            bus.seg    <= seg_logical ^ SEG_XOR;
            bus.dig_en <= onehot ^ DIG_XOR;
        end
    end
endmodule

// File: tb/tb_bcd_7seg_scan_driver.sv
// Randomised self-checking bench: three driver instances (4-digit, 4-digit inverted, 1-digit)
// compared against a cycle-count based reference model of the display.
module tb_bcd_7seg_scan_driver;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] bcd_in = 16'h0000;
    logic        le = 1'b0;
    logic        lt_n = 1'b1;
    logic        bi_n = 1'b1;

    int checks = 0;
    int failures = 0;

    bcd_7seg_scan_driver_if #(.N_DIGITS(4)) if0 ();
    bcd_7seg_scan_driver_if #(.N_DIGITS(4)) if1 ();
    bcd_7seg_scan_driver_if #(.N_DIGITS(1)) if2 ();

    assign if0.bcd_in = bcd_in;
    assign if0.le = le;
    assign if0.lt_n = lt_n;
    assign if0.bi_n = bi_n;
    assign if1.bcd_in = bcd_in;
    assign if1.le = le;
    assign if1.lt_n = lt_n;
    assign if1.bi_n = bi_n;
    assign if2.bcd_in = bcd_in[3:0];
    assign if2.le = le;
    assign if2.lt_n = lt_n;
    assign if2.bi_n = bi_n;

    bcd_7seg_scan_driver #(.N_DIGITS(4), .CLK_DIV(4), .SEG_ACTIVE_LOW(0), .DIGIT_ACTIVE_LOW(0))
        u0 (.clk(clk), .rst(rst), .bus(if0.slave));
    bcd_7seg_scan_driver #(.N_DIGITS(4), .CLK_DIV(4), .SEG_ACTIVE_LOW(1), .DIGIT_ACTIVE_LOW(1))
        u1 (.clk(clk), .rst(rst), .bus(if1.slave));
    bcd_7seg_scan_driver #(.N_DIGITS(1), .CLK_DIV(3), .SEG_ACTIVE_LOW(0), .DIGIT_ACTIVE_LOW(0))
        u2 (.clk(clk), .rst(rst), .bus(if2.slave));

    always #5 clk = ~clk;

    // Reference model: everything derived from the number of clock edges since reset release.
    int          cyc = 0;
    logic [15:0] m_latch = '0;
    logic [6:0]  e0_seg = '0;
    logic [3:0]  e0_dig = '0;
    logic        e0_tick = 1'b0;
    logic [6:0]  e2_seg = '0;
    logic        e2_dig = 1'b0;
    logic        e2_tick = 1'b0;
    logic [6:0]  seg_tbl [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                                  7'b1011011, 7'b0011111, 7'b1110000, 7'b1111111, 7'b1110011};

    function automatic logic [6:0] model_seg(input logic [15:0] lat, input int idx);
        int d;
        if (!lt_n) return 7'b1111111;
        if (!bi_n) return 7'b0000000;
        d = int'((lat >> (4 * idx)) & 16'hF);
`ifdef LZB_EN
        if (idx != 0 && (lat >> (4 * idx)) == 16'h0) return 7'b0000000;
`endif
        return (d < 10) ? seg_tbl[d] : 7'b0000000;
    endfunction

    function automatic int model_idx();
        return (cyc / 4) % 4;
    endfunction

    task automatic step();
        int idx;
        @(posedge clk);
        if (rst) begin
            cyc = 0;
            m_latch = '0;
            e0_seg = '0; e0_dig = '0; e0_tick = 1'b0;
            e2_seg = '0; e2_dig = 1'b0; e2_tick = 1'b0;
        end else begin
            idx = model_idx();
            e0_seg = model_seg(m_latch, idx);
            e0_dig = 4'(1 << idx);
            e2_seg = model_seg({12'h000, m_latch[3:0]}, 0);
            e2_dig = 1'b1;
            cyc++;
            e0_tick = (cyc % 4 == 0);
            e2_tick = (cyc % 3 == 0);
            if (!le) m_latch = bcd_in;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; le = 1'b0; lt_n = 1'b1; bi_n = 1'b1; bcd_in = 16'h5678;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (if0.seg !== 7'b0000000 || if0.dig_en !== 4'b0000 || if0.scan_tick !== 1'b0) begin
                failures++;
                $display("FAIL reset_u0 seg=%b dig=%b tick=%b required seg=0000000 dig=0000 tick=0",
                         if0.seg, if0.dig_en, if0.scan_tick);
            end
            checks++;
            if (if1.seg !== 7'b1111111 || if1.dig_en !== 4'b1111) begin
                failures++;
                $display("FAIL reset_u1 seg=%b dig=%b required seg=1111111 dig=1111", if1.seg, if1.dig_en);
            end
        end
        rst = 1'b0;
        step();
        checks++;
        if (if0.dig_en !== 4'b0001) begin
            failures++;
            $display("FAIL reset_release dig=%b required 0001", if0.dig_en);
        end
    endtask

    task automatic test_scan();
        for (int i = 0; i < 24; i++) begin
            step();
            checks++;
            if (if0.dig_en !== e0_dig || if0.scan_tick !== e0_tick) begin
                failures++;
                $display("FAIL scan_u0 cyc=%0d dig=%b tick=%b required dig=%b tick=%b",
                         cyc, if0.dig_en, if0.scan_tick, e0_dig, e0_tick);
            end
            checks++;
            if (if2.dig_en !== e2_dig || if2.scan_tick !== e2_tick) begin
                failures++;
                $display("FAIL scan_n1 cyc=%0d dig=%b tick=%b required dig=%b tick=%b",
                         cyc, if2.dig_en, if2.scan_tick, e2_dig, e2_tick);
            end
        end
    endtask

    task automatic test_latch();
        le = 1'b0; bcd_in = 16'h1234;
        for (int i = 0; i < 20; i++) begin
            step();
            checks++;
            if (if0.seg !== e0_seg || if0.dig_en !== e0_dig) begin
                failures++;
                $display("FAIL latch_open seg=%b dig=%b required seg=%b dig=%b",
                         if0.seg, if0.dig_en, e0_seg, e0_dig);
            end
        end
        le = 1'b1; bcd_in = 16'h9999;
        for (int i = 0; i < 20; i++) begin
            step();
            checks++;
            if (if0.seg !== e0_seg) begin
                failures++;
                $display("FAIL latch_hold seg=%b required %b", if0.seg, e0_seg);
            end
            checks++;
            if (if0.dig_en === 4'b0001 && if0.seg !== 7'b0110011) begin
                failures++;
                $display("FAIL latch_hold_digit0 seg=%b required 0110011", if0.seg);
            end
        end
    endtask

    task automatic test_lamp_blank();
        le = 1'b0; bcd_in = 16'h2580; lt_n = 1'b0; bi_n = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            checks++;
            if (if0.seg !== 7'b1111111 || if1.seg !== 7'b0000000) begin
                failures++;
                $display("FAIL lamp_test seg0=%b seg1=%b required 1111111 / 0000000", if0.seg, if1.seg);
            end
        end
        lt_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            checks++;
            if (if0.seg !== 7'b0000000 || if0.dig_en !== e0_dig) begin
                failures++;
                $display("FAIL blank seg=%b dig=%b required seg=0000000 dig=%b", if0.seg, if0.dig_en, e0_dig);
            end
        end
        bi_n = 1'b1;
    endtask

    task automatic test_invalid_polarity();
        le = 1'b0; bcd_in = 16'hFADC;
        for (int i = 0; i < 16; i++) begin
            step();
            checks++;
            if (if0.seg !== e0_seg || if1.seg !== ~e0_seg || if1.dig_en !== ~e0_dig) begin
                failures++;
                $display("FAIL invalid_codes seg0=%b seg1=%b dig1=%b required %b %b %b",
                         if0.seg, if1.seg, if1.dig_en, e0_seg, ~e0_seg, ~e0_dig);
            end
        end
        bcd_in = 16'h8181;
        for (int i = 0; i < 16; i++) begin
            step();
            checks++;
            if (if1.seg !== ~e0_seg) begin
                failures++;
                $display("FAIL active_low seg1=%b required %b", if1.seg, ~e0_seg);
            end
        end
    endtask

    task automatic test_lzb();
        logic [15:0] pats [2] = '{16'h0070, 16'h0000};
        le = 1'b0;
        for (int p = 0; p < 2; p++) begin
            bcd_in = pats[p];
            for (int i = 0; i < 18; i++) begin
                step();
                checks++;
                if (if0.seg !== e0_seg || if2.seg !== e2_seg) begin
                    failures++;
                    $display("FAIL lzb pat=%h dig=%b seg0=%b seg2=%b required %b %b",
                             pats[p], if0.dig_en, if0.seg, if2.seg, e0_seg, e2_seg);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            bcd_in = 16'($urandom);
            le     = ($urandom_range(0, 3) == 0);
            lt_n   = ($urandom_range(0, 9) != 0);
            bi_n   = ($urandom_range(0, 9) != 0);
            step();
            checks++;
            if (if0.seg !== e0_seg || if0.dig_en !== e0_dig || if0.scan_tick !== e0_tick) begin
                failures++;
                $display("FAIL random_u0 cyc=%0d seg=%b dig=%b tick=%b required %b %b %b",
                         cyc, if0.seg, if0.dig_en, if0.scan_tick, e0_seg, e0_dig, e0_tick);
            end
            checks++;
            if (if1.seg !== ~e0_seg || if1.dig_en !== ~e0_dig) begin
                failures++;
                $display("FAIL random_u1 seg=%b dig=%b required %b %b", if1.seg, if1.dig_en, ~e0_seg, ~e0_dig);
            end
            checks++;
            if (if2.seg !== e2_seg || if2.dig_en !== e2_dig || if2.scan_tick !== e2_tick) begin
                failures++;
                $display("FAIL random_n1 seg=%b dig=%b tick=%b required %b %b %b",
                         if2.seg, if2.dig_en, if2.scan_tick, e2_seg, e2_dig, e2_tick);
            end
        end
        lt_n = 1'b1; bi_n = 1'b1; le = 1'b0;
    endtask

    task automatic test_reset_midscan();
        int n;
        int gap;
        n = 0;
        while (model_idx() != 2 && n < 40) begin
            step();
            n++;
        end
        checks++;
        if (model_idx() != 2) begin
            failures++;
            $display("FAIL midscan_reach idx=%0d required 2", model_idx());
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        checks++;
        if (if0.dig_en !== 4'b0001) begin
            failures++;
            $display("FAIL midscan_release dig=%b required 0001", if0.dig_en);
        end
        gap = 1;
        while (if0.scan_tick !== 1'b1 && gap < 12) begin
            step();
            gap++;
        end
        checks++;
        if (gap != 4) begin
            failures++;
            $display("FAIL midscan_first_tick gap=%0d required 4", gap);
        end
        step();
        checks++;
        if (if0.dig_en !== 4'b0010) begin
            failures++;
            $display("FAIL midscan_advance dig=%b required 0010", if0.dig_en);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_scan();
        test_latch();
        test_lamp_blank();
        test_invalid_polarity();
        test_lzb();
        test_random();
        test_reset_midscan();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
